regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per register.
REQ-002 SHALL have parameter DEPTH, default 8, register count, power of two, at least 4.
REQ-003 SHALL have parameter NREAD, default 2, number of independent read ports, at least 1.
REQ-004 SHALL derive localparam AW = $clog2(DEPTH), address width.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 rd_addr  input  NREAD*AW  packed read addresses; port i in bits [i*AW +: AW].
REQ-008 rd_data  output  NREAD*WIDTH  packed read data, port i in bits [i*WIDTH +: WIDTH].
REQ-009 rd_busy  output  NREAD  port i addresses a register with a pending reservation.
REQ-010 wr_en  input  1  write strobe.
REQ-011 wr_addr  input  AW  write address.
REQ-012 wr_data  input  WIDTH  write data.
REQ-013 rsv_en  input  1  reservation request; marks destination busy for a multicycle producer.
REQ-014 rsv_addr  input  AW  register to reserve.
REQ-015 rsv_ok  output  1  reservation granted this cycle.
REQ-016 busy_vec  output  DEPTH  per-register busy flags, bit n for register n.

Function
REQ-017 Register 0 SHALL always read as zero; writes to it SHALL be ignored; busy_vec[0] SHALL always be 0.
REQ-018 Writes SHALL commit on the rising clk edge when wr_en=1 and wr_addr!=0.
REQ-019 Reads SHALL be combinational with write-first bypass: if wr_en=1, wr_addr==rd_addr[i], and wr_addr!=0, rd_data[i] SHALL equal wr_data in the same cycle.
REQ-020 Every read port SHALL bypass independently; all ports SHALL be able to address the same register.
REQ-021 A committed write SHALL clear busy for wr_addr at the same edge.
REQ-022 rd_busy[i] SHALL be busy_vec[rd_addr[i]] AND NOT (wr_en AND wr_addr==rd_addr[i]); a same-cycle write releases the busy indication.
REQ-023 rsv_ok SHALL be rsv_en AND (busy_vec[rsv_addr]==0 OR (wr_en AND wr_addr==rsv_addr)).
REQ-024 rsv_ok SHALL always be 1 when rsv_en=1 and rsv_addr=0; such a grant SHALL change no state.
REQ-025 A granted reservation to a nonzero register SHALL set its busy flag at the next edge; a denied one SHALL change no state.
REQ-026 When a write and a granted reservation target the same register in one cycle, data SHALL be written and busy SHALL end set.
REQ-027 A write to a non-busy register SHALL be legal and leave busy clear.
REQ-028 Register contents SHALL NOT change on reservation.

Reset
REQ-029 While rst=1, all registers, busy_vec, rd_busy and rd_data SHALL be zero regardless of clk, and rsv_ok SHALL be 0.
REQ-030 rst asserted mid-operation SHALL discard all writes and reservations presented in that cycle.
REQ-031 After rst deasserts, the first clk edge SHALL accept writes and reservations.

Structure
REQ-032 Package regfile_pkg SHALL hold the default WIDTH, DEPTH, and NREAD constants and the address and data typedefs.
REQ-033 Busy tracking SHALL live in sub-module rf_scoreboard, with ports clk, rst, set_en/set_addr, clr_en/clr_addr, and busy_vec.

Verification
REQ-034 Reset, then read all addresses on both ports -> every rd_data=0x00, busy_vec=0x00.
REQ-035 Write 0xA5 to r3 while rd_addr0=3 -> rd_data0=0xA5 in the same cycle; the next cycle still 0xA5. Write 0xFF to r0 -> reads 0x00.
REQ-036 Reserve r5 -> rsv_ok=1 and busy_vec=0x20 next cycle; reserve r5 again -> rsv_ok=0; write 0x3C to r5 -> rd_busy=0 in the same cycle, busy_vec=0x00 next.
REQ-037 In one cycle, write 0x11 to r5 (busy) and reserve r5 -> rsv_ok=1, r5 reads 0x11, busy_vec[5]=1 after the edge.
REQ-038 Load r1..r7 with 0x01..0x07, reserve r2, assert rst asynchronously mid-cycle -> all reads 0x00 and busy_vec=0 immediately, with no clk edge required.
REQ-039 With NREAD=4, WIDTH=16, DEPTH=16, read r9 on all ports during a write of 0xBEEF to r9 -> all four ports show 0xBEEF.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared sizing constants and default-width types for the scoreboarded register file.
package regfile_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_NREAD = 2;
  localparam int DEF_AW    = $clog2(DEF_DEPTH);

  typedef logic [DEF_AW-1:0]    addr_t;
  typedef logic [DEF_WIDTH-1:0] data_t;
endpackage

// File: rtl/regfile_sb_if.sv
// Register-file access bus: read ports, write port, reservation port and busy status.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int NREAD = DEF_NREAD
);
  localparam int AW = $clog2(DEPTH);

  logic [NREAD*AW-1:0]    rd_addr;
  logic [NREAD*WIDTH-1:0] rd_data;
  logic [NREAD-1:0]       rd_busy;
  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [WIDTH-1:0]       wr_data;
  logic                   rsv_en;
  logic [AW-1:0]          rsv_addr;
  logic                   rsv_ok;
  logic [DEPTH-1:0]       busy_vec;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_busy, rsv_ok, busy_vec
  );
  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_busy, rsv_ok, busy_vec
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy flags: set by granted reservations, cleared by committed writes.
module rf_scoreboard #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  output logic [DEPTH-1:0] busy_vec
);
  logic [DEPTH-1:0] r_busy;

  // Set is applied after clear so a same-cycle write+reserve leaves the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      if (clr_en) r_busy[clr_addr] <= 1'b0;
      if (set_en) r_busy[set_addr] <= 1'b1;
      r_busy[0] <= 1'b0;
    end
  end

  assign busy_vec = r_busy;
endmodule

// File: rtl/regfile_sb.sv
// Multi-read register file with write-first bypass and a reservation scoreboard; r0 is hardwired zero.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int NREAD = DEF_NREAD
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [DEPTH-1:0]            w_busy;
  logic                        w_we;
  logic                        w_rsv_ok;
  logic                        w_set;
  logic [AW-1:0]               w_ra;
  logic [NREAD*WIDTH-1:0]      w_rd_data;
  logic [NREAD-1:0]            w_rd_busy;

  // Reset also masks the bypass path so nothing leaks out while rst is high.
  assign w_we     = bus.wr_en && !rst && (bus.wr_addr != '0);
  assign w_rsv_ok = !rst && bus.rsv_en &&
                    (!w_busy[bus.rsv_addr] || (bus.wr_en && bus.wr_addr == bus.rsv_addr));
  assign w_set    = w_rsv_ok && (bus.rsv_addr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_mem <= '0;
    else if (w_we) r_mem[bus.wr_addr] <= bus.wr_data;
  end

  rf_scoreboard #(.DEPTH(DEPTH), .AW(AW)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (w_set),
    .set_addr (bus.rsv_addr),
    .clr_en   (w_we),
    .clr_addr (bus.wr_addr),
    .busy_vec (w_busy)
  );

  always_comb begin
    w_rd_data = '0;
    w_rd_busy = '0;
    w_ra      = '0;
    for (int i = 0; i < NREAD; i++) begin
      w_ra = bus.rd_addr[i*AW +: AW];
      if (!rst) begin
        if (w_we && bus.wr_addr == w_ra) w_rd_data[i*WIDTH +: WIDTH] = bus.wr_data;
        else                             w_rd_data[i*WIDTH +: WIDTH] = r_mem[w_ra];
        w_rd_busy[i] = w_busy[w_ra] && !(bus.wr_en && bus.wr_addr == w_ra);
      end
    end
  end

  assign bus.rd_data  = w_rd_data;
  assign bus.rd_busy  = w_rd_busy;
  assign bus.rsv_ok   = w_rsv_ok;
  assign bus.busy_vec = w_busy;
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table, random run against an array model, reset and wide-config sequences.
module tb_regfile_sb;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_sb_if #(.WIDTH(8), .DEPTH(8), .NREAD(2)) bus ();
  regfile_sb #(.WIDTH(8), .DEPTH(8), .NREAD(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  regfile_sb_if #(.WIDTH(16), .DEPTH(16), .NREAD(4)) wbus ();
  regfile_sb #(.WIDTH(16), .DEPTH(16), .NREAD(4)) dut_w (.clk(clk), .rst(rst), .bus(wbus));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic  we; addr_t wa; data_t wd; logic re; addr_t ra; addr_t a0; addr_t a1;
    data_t d0; data_t d1; logic [1:0] rb; logic ok; logic [7:0] ba;
  } vec_t;
  vec_t tbl [16];

  data_t m_mem  [8];
  logic  m_busy [8];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int we, int wa, int wd, int re, int ra, int a0, int a1,
                              int d0, int d1, int rb, int ok, int ba);
    vec_t v;
    v.we = we[0]; v.wa = addr_t'(wa); v.wd = data_t'(wd);
    v.re = re[0]; v.ra = addr_t'(ra); v.a0 = addr_t'(a0); v.a1 = addr_t'(a1);
    v.d0 = data_t'(d0); v.d1 = data_t'(d1); v.rb = rb[1:0]; v.ok = ok[0]; v.ba = ba[7:0];
    return v;
  endfunction

  task automatic drive(int we, int wa, int wd, int re, int ra, int a0, int a1);
    bus.wr_en = we[0]; bus.wr_addr = addr_t'(wa); bus.wr_data = data_t'(wd);
    bus.rsv_en = re[0]; bus.rsv_addr = addr_t'(ra);
    bus.rd_addr = {addr_t'(a1), addr_t'(a0)};
  endtask

  // Reference model: architectural view of the file, from the stated rules.
  function automatic data_t m_read(addr_t a);
    if (a == 0) return '0;
    if (bus.wr_en && bus.wr_addr == a) return bus.wr_data;
    return m_mem[a];
  endfunction
  function automatic logic m_rbusy(addr_t a);
    return m_busy[a] && !(bus.wr_en && bus.wr_addr == a);
  endfunction
  function automatic logic m_ok();
    return bus.rsv_en && (bus.rsv_addr == 0 || !m_busy[bus.rsv_addr] ||
                          (bus.wr_en && bus.wr_addr == bus.rsv_addr));
  endfunction
  function automatic logic [7:0] m_bvec();
    logic [7:0] v = '0;
    for (int n = 1; n < 8; n++) v[n] = m_busy[n];
    return v;
  endfunction
  task automatic m_commit();
    logic ok = m_ok();
    if (bus.wr_en && bus.wr_addr != 0) begin
      m_mem[bus.wr_addr] = bus.wr_data;
      m_busy[bus.wr_addr] = 1'b0;
    end
    if (ok && bus.rsv_addr != 0) m_busy[bus.rsv_addr] = 1'b1;
  endtask
  task automatic m_reset();
    for (int n = 0; n < 8; n++) begin m_mem[n] = '0; m_busy[n] = 1'b0; end
  endtask

  initial begin
    m_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    wbus.wr_en = 1'b0; wbus.wr_addr = '0; wbus.wr_data = '0;
    wbus.rsv_en = 1'b0; wbus.rsv_addr = '0; wbus.rd_addr = '0;

    tbl[0]  = mk(1, 3, 'hA5, 0, 0, 3, 0,  'hA5, 'h00, 0, 0, 'h00);
    tbl[1]  = mk(0, 0, 0,    0, 0, 3, 3,  'hA5, 'hA5, 0, 0, 'h00);
    tbl[2]  = mk(1, 0, 'hFF, 0, 0, 0, 3,  'h00, 'hA5, 0, 0, 'h00);
    tbl[3]  = mk(0, 0, 0,    0, 0, 0, 3,  'h00, 'hA5, 0, 0, 'h00);
    tbl[4]  = mk(0, 0, 0,    1, 5, 5, 0,  'h00, 'h00, 0, 1, 'h20);
    tbl[5]  = mk(0, 0, 0,    1, 5, 5, 0,  'h00, 'h00, 1, 0, 'h20);
    tbl[6]  = mk(1, 5, 'h3C, 0, 0, 5, 5,  'h3C, 'h3C, 0, 0, 'h00);
    tbl[7]  = mk(0, 0, 0,    1, 5, 5, 3,  'h3C, 'hA5, 0, 1, 'h20);
    tbl[8]  = mk(1, 5, 'h11, 1, 5, 5, 0,  'h11, 'h00, 0, 1, 'h20);
    tbl[9]  = mk(0, 0, 0,    0, 0, 5, 5,  'h11, 'h11, 3, 0, 'h20);
    tbl[10] = mk(0, 0, 0,    1, 0, 0, 5,  'h00, 'h11, 2, 1, 'h20);
    tbl[11] = mk(1, 5, 'h22, 0, 0, 5, 0,  'h22, 'h00, 0, 0, 'h00);
    tbl[12] = mk(1, 2, 'h44, 0, 0, 2, 5,  'h44, 'h22, 0, 0, 'h00);
    tbl[13] = mk(0, 0, 0,    1, 3, 3, 2,  'hA5, 'h44, 0, 1, 'h08);
    tbl[14] = mk(1, 4, 'h55, 1, 3, 3, 4,  'hA5, 'h55, 1, 0, 'h08);
    tbl[15] = mk(1, 3, 'h66, 0, 0, 3, 4,  'h66, 'h55, 0, 0, 'h00);

    // Held in reset: every output zero, even with a write and reservation presented.
    #3;
    for (int a = 0; a < 8; a++) begin
      drive(0, 0, 0, 0, 0, a, a); #1;
      chk($sformatf("rst_rd0_a%0d", a), bus.rd_data[7:0], 0);
      chk($sformatf("rst_rd1_a%0d", a), bus.rd_data[15:8], 0);
    end
    drive(1, 3, 'h5A, 1, 1, 3, 1); #1;
    chk("rst_bypass_masked", bus.rd_data, 0);
    chk("rst_rsv_ok", bus.rsv_ok, 0);
    chk("rst_busy_vec", bus.busy_vec, 0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0); rst = 1'b0;
    for (int a = 0; a < 8; a++) begin
      drive(0, 0, 0, 0, 0, a, a); #1;
      chk($sformatf("post_rst_rd_a%0d", a), bus.rd_data, 0);
    end
    chk("post_rst_busy_vec", bus.busy_vec, 0);

    foreach (tbl[k]) begin
      @(negedge clk);
      drive(tbl[k].we, tbl[k].wa, tbl[k].wd, tbl[k].re, tbl[k].ra, tbl[k].a0, tbl[k].a1);
      #2;
      chk($sformatf("tbl%0d_rd0", k), bus.rd_data[7:0], tbl[k].d0);
      chk($sformatf("tbl%0d_rd1", k), bus.rd_data[15:8], tbl[k].d1);
      chk($sformatf("tbl%0d_rd_busy", k), bus.rd_busy, tbl[k].rb);
      chk($sformatf("tbl%0d_rsv_ok", k), bus.rsv_ok, tbl[k].ok);
      m_commit();
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_busy_vec", k), bus.busy_vec, tbl[k].ba);
    end

    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      drive($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 255),
            $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 7));
      #2;
      chk($sformatf("rnd%0d_rd0", k), bus.rd_data[7:0], m_read(bus.rd_addr[2:0]));
      chk($sformatf("rnd%0d_rd1", k), bus.rd_data[15:8], m_read(bus.rd_addr[5:3]));
      chk($sformatf("rnd%0d_rd_busy", k), bus.rd_busy,
          {m_rbusy(bus.rd_addr[5:3]), m_rbusy(bus.rd_addr[2:0])});
      chk($sformatf("rnd%0d_rsv_ok", k), bus.rsv_ok, m_ok());
      m_commit();
      @(posedge clk); #1;
      chk($sformatf("rnd%0d_busy_vec", k), bus.busy_vec, m_bvec());
    end

    // Load r1..r7, reserve r2, then assert rst between edges with traffic pending.
    for (int r = 1; r < 8; r++) begin
      @(negedge clk); drive(1, r, r, 0, 0, 0, 0); m_commit();
    end
    @(negedge clk); drive(0, 0, 0, 1, 2, 0, 0); m_commit();
    @(negedge clk); drive(1, 6, 'h77, 1, 4, 6, 2); #1;
    chk("pre_rst_bypass", bus.rd_data[7:0], 'h77);
    chk("pre_rst_r2", bus.rd_data[15:8], 'h02);
    chk("pre_rst_r2_busy", bus.rd_busy, 2'b10);
    #1; rst = 1'b1; #1;
    chk("async_rst_rd", bus.rd_data, 0);
    chk("async_rst_busy_vec", bus.busy_vec, 0);
    chk("async_rst_rd_busy", bus.rd_busy, 0);
    chk("async_rst_rsv_ok", bus.rsv_ok, 0);
    m_reset();
    @(posedge clk); #1;
    for (int a = 0; a < 8; a++) begin
      bus.rd_addr = {addr_t'(a), addr_t'(a)}; #1;
      chk($sformatf("rst_hold_rd_a%0d", a), bus.rd_data, 0);
    end
    chk("rst_hold_busy_vec", bus.busy_vec, 0);
    @(negedge clk); drive(1, 6, 'h77, 1, 4, 6, 4); rst = 1'b0; #2;
    chk("first_edge_bypass", bus.rd_data[7:0], m_read(6));
    chk("first_edge_rsv_ok", bus.rsv_ok, m_ok());
    m_commit();
    @(posedge clk); #1;
    chk("first_edge_busy_vec", bus.busy_vec, m_bvec());
    @(negedge clk); drive(0, 0, 0, 0, 0, 6, 1); #1;
    chk("first_edge_r6", bus.rd_data[7:0], m_read(6));
    chk("first_edge_r1_cleared", bus.rd_data[15:8], m_read(1));

    // Wide configuration: four ports on one register during a write, then mixed addresses.
    @(negedge clk);
    wbus.wr_en = 1'b1; wbus.wr_addr = 4'd9; wbus.wr_data = 16'hBEEF;
    wbus.rd_addr = {4'd9, 4'd9, 4'd9, 4'd9}; #1;
    for (int p = 0; p < 4; p++) chk($sformatf("wide_bypass_p%0d", p), wbus.rd_data[p*16 +: 16], 'hBEEF);
    @(negedge clk);
    wbus.wr_addr = 4'd15; wbus.wr_data = 16'h1234;
    wbus.rd_addr = {4'd9, 4'd15, 4'd9, 4'd0}; #1;
    chk("wide_mix_p0", wbus.rd_data[15:0], 'h0000);
    chk("wide_mix_p1", wbus.rd_data[31:16], 'hBEEF);
    chk("wide_mix_p2", wbus.rd_data[47:32], 'h1234);
    chk("wide_mix_p3", wbus.rd_data[63:48], 'hBEEF);
    @(negedge clk); wbus.wr_en = 1'b0; #1;
    chk("wide_hold_p2", wbus.rd_data[47:32], 'h1234);
    chk("wide_hold_p3", wbus.rd_data[63:48], 'hBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
